// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - EX/MEM, data RAM and MEM/WB signal bundle for the MEM stage
interface mem_access_stage_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m_valid;
    logic [3:0]    m_op;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_alu;
    logic [4:0]    m_rd;
    logic          m_wreg;
    logic          stall;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_datain;
    logic [DW-1:0] ram_dataout;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic [4:0]    w_rd;
    logic          w_wreg;
    logic          misalign;

    // MEM stage view
    modport slave (
        input  m_valid, m_op, m_addr, m_wdata, m_alu, m_rd, m_wreg, ram_dataout,
        output stall, ram_we, ram_addr, ram_datain, w_valid, w_data, w_rd, w_wreg, misalign
    );

    // Pipeline / RAM side view
    modport master (
        output m_valid, m_op, m_addr, m_wdata, m_alu, m_rd, m_wreg, ram_dataout,
        input  stall, ram_we, ram_addr, ram_datain, w_valid, w_data, w_rd, w_wreg, misalign
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage with big-endian sub-word loads and read-modify-write sub-word stores
module mem_access_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave bus
);
    typedef enum logic { IDLE = 1'b0, RMW_WR = 1'b1 } state_t;

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SB  = 4'd10;

    state_t        state_q, state_d;
    logic [DW-1:0] old_word_q, old_word_d;
    logic          w_valid_q, w_valid_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [4:0]    w_rd_q, w_rd_d;
    logic          w_wreg_q, w_wreg_d;
    logic          misalign_q, misalign_d;

    logic          is_word, is_half, is_byte, is_load, is_store, is_sub_store;
    logic          aligned, mis_access, rmw_start;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_data, merged;

    assign is_word      = (bus.m_op == OP_LW) || (bus.m_op == OP_SW);
    assign is_half      = (bus.m_op == OP_LH) || (bus.m_op == OP_LHU) || (bus.m_op == OP_SH);
    assign is_byte      = (bus.m_op == OP_LB) || (bus.m_op == OP_LBU) || (bus.m_op == OP_SB);
    assign is_load      = (bus.m_op >= OP_LW) && (bus.m_op <= OP_LBU);
    assign is_store     = (bus.m_op >= OP_SW) && (bus.m_op <= OP_SB);
    assign is_sub_store = (bus.m_op == OP_SH) || (bus.m_op == OP_SB);

    assign aligned    = is_byte || (is_half && !bus.m_addr[0]) ||
                        (is_word && (bus.m_addr[1:0] == 2'b00));
    assign mis_access = bus.m_valid && (is_load || is_store) && !aligned;
    assign rmw_start  = (state_q == IDLE) && bus.m_valid && is_sub_store && aligned;

    // Big-endian lane extraction from the addressed RAM word
    always_comb begin
        byte_sel = bus.ram_dataout[31:24];
        case (bus.m_addr[1:0])
            2'd0:    byte_sel = bus.ram_dataout[31:24];
            2'd1:    byte_sel = bus.ram_dataout[23:16];
            2'd2:    byte_sel = bus.ram_dataout[15:8];
            default: byte_sel = bus.ram_dataout[7:0];
        endcase
        half_sel = bus.m_addr[1] ? bus.ram_dataout[15:0] : bus.ram_dataout[31:16];
        case (bus.m_op)
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = bus.ram_dataout;
        endcase
    end

    // Splice the store lane into the word captured during the stall cycle
    always_comb begin
        merged = old_word_q;
        if (bus.m_op == OP_SB) begin
            case (bus.m_addr[1:0])
                2'd0:    merged[31:24] = bus.m_wdata[7:0];
                2'd1:    merged[23:16] = bus.m_wdata[7:0];
                2'd2:    merged[15:8]  = bus.m_wdata[7:0];
                default: merged[7:0]   = bus.m_wdata[7:0];
            endcase
        end else if (bus.m_addr[1]) begin
            merged[15:0] = bus.m_wdata[15:0];
        end else begin
            merged[31:16] = bus.m_wdata[15:0];
        end
    end

    // RAM side: word stores go straight through, sub-word stores write on the second cycle
    always_comb begin
        bus.ram_addr = {bus.m_addr[AW-1:2], 2'b00};
        bus.stall    = rmw_start;
        if (state_q == RMW_WR) begin
            bus.ram_we     = 1'b1;
            bus.ram_datain = merged;
        end else begin
            bus.ram_we     = bus.m_valid && (bus.m_op == OP_SW) && aligned;
            bus.ram_datain = bus.m_wdata;
        end
    end

    // Next-state and MEM/WB contents; a stall cycle inserts a bubble
    always_comb begin
        state_d    = IDLE;
        old_word_d = old_word_q;
        w_valid_d  = bus.m_valid;
        w_data_d   = bus.m_alu;
        w_rd_d     = bus.m_rd;
        w_wreg_d   = 1'b0;
        misalign_d = 1'b0;
        if (state_q == RMW_WR) begin
            w_valid_d = 1'b1;
        end else if (rmw_start) begin
            state_d    = RMW_WR;
            old_word_d = bus.ram_dataout;
            w_valid_d  = 1'b0;
        end else begin
            misalign_d = mis_access;
            if (is_load && aligned)
                w_data_d = load_data;
            w_wreg_d = bus.m_valid && bus.m_wreg && !is_store && !mis_access;
        end
    end

    // FSM state and registered MEM/WB outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            old_word_q <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_rd_q     <= '0;
            w_wreg_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            old_word_q <= old_word_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_rd_q     <= w_rd_d;
            w_wreg_q   <= w_wreg_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.w_valid  = w_valid_q;
    assign bus.w_data   = w_data_q;
    assign bus.w_rd     = w_rd_q;
    assign bus.w_wreg   = w_wreg_q;
    assign bus.misalign = misalign_q;
endmodule
